issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  In-order circular issue queue between decode and execute. Accepts up to 4 decoded
//  ISSUE_QUEUE_ELEMENTs per cycle from decode (push count plus free-space back-pressure).
//  Presents the oldest POP_W entries to the issue/execute stage, which retires 0..POP_W
//  of them per cycle. Supports full flush on branch mispredict/exception.
// PARAMETERS
//  DEPTH  16  queue entries; power of two, >= 8
//  POP_W  2   max entries presented/consumed per cycle (1..4)
// PORTS
//  clk                      in   1                        clock
//  rst                      in   1                        synchronous reset, active-high
//  flush                    in   1                        discard all entries
//  issue_queue_element      in   ISSUE_QUEUE_ELEMENT[3:0] decoded slots; slot 0 is oldest
//  issue_queue_push_number  in   3                        slots to enqueue, 0..4
//  iq_size_left             out  3                        free entries, saturated at 4
//  issue_element            out  ISSUE_QUEUE_ELEMENT[POP_W-1:0]  oldest entries; [0] oldest
//  issue_valid              out  POP_W                    thermometer valid for issue_element
//  issue_pop_number         in   $clog2(POP_W+1)          entries consumed this cycle
// BEHAVIOUR
//  - State: head, tail (log2 DEPTH bits, wrap mod DEPTH), count (log2 DEPTH + 1 bits).
//    Storage: DEPTH x ISSUE_QUEUE_ELEMENT registers; no reset needed on payload.
//  - Reset (rst=1 at posedge): head=tail=count=0. Next cycle issue_valid=0 and iq_size_left=4.
//  - iq_size_left = min(DEPTH-count, 4), combinational from current count.
//    It does not include this cycle's pop.
//  - Push: eff_push = min(issue_queue_push_number, iq_size_left).
//    Slot k (k < eff_push) is written to mem[(tail+k) mod DEPTH]; tail += eff_push.
//    Slots k >= eff_push are ignored. If the request exceeds the limit, the extra slots are
//    dropped silently. Decode must never request more than the limit; the bench flags any
//    violation.
//  - Issue view: first-word fall-through with zero latency.
//    issue_element[j] = mem[(head+j) mod DEPTH].
//    issue_valid[j] = (j < count).
//    A pushed entry becomes visible the cycle after its push.
//  - Pop: eff_pop = min(issue_pop_number, count); head += eff_pop.
//    Popping invalid slots is clamped and has no effect.
//  - Same-cycle push and pop are both applied: count_next = count + eff_push - eff_pop.
//    Push space is judged before the pop, so the queue never overflows.
//    When the queue is full (count=DEPTH), push is 0 even if a pop occurs that cycle.
//  - Flush: head=tail=count=0. Flush overrides push and pop in the same cycle.
//    Next cycle issue_valid=0 and iq_size_left=4.
//  - rst has priority over flush. Reset mid-stream discards all contents.
//  - Wrap-around: pointer arithmetic is mod DEPTH.
//    A 4-slot push starting at tail=DEPTH-2 writes entries DEPTH-2, DEPTH-1, 0, 1.
//  - Order is strictly FIFO: entries issue in push order, and slot order within a push is kept.
//  - Invariants, asserted in simulation:
//    - count <= DEPTH;
//    - (tail - head) mod DEPTH == count mod DEPTH;
//    - issue_valid is a thermometer code.
// TESTING
//  1. Reset: after rst, issue_valid=00, iq_size_left=4. Push 3 (A,B,C), pop 0
//     -> next cycle count=3, issue_element[0]=A, [1]=B, valid=11.
//  2. Fill: push 4 per cycle for 4 cycles with no pop -> count=16, iq_size_left=0.
//     A 5th push of 4 is dropped and count stays 16.
//  3. Near-full clamp: count=14, push_number=4 -> iq_size_left=2, only slots 0 and 1 are
//     written, count=16. The bench flags the protocol violation.
//  4. Simultaneous: count=2, push 4, pop 2 -> count=4. The new head is the first pushed
//     entry and order is preserved.
//  5. Wrap: head=tail=14, count=0. Push W,X,Y,Z -> stored at 14, 15, 0, 1.
//     Then pop 2/cycle for 2 cycles -> issues W,X then Y,Z, and count=0.
//  6. Flush: count=9, flush=1 together with push 4 and pop 2 -> next cycle count=0,
//     valid=00, iq_size_left=4. rst together with flush gives the same result.

Source files
------------

// File: rtl/issue_queue.sv
// Issue queue types and in-order circular issue queue between decode and execute.
// Decode pushes up to four decoded slots per cycle, limited by the free space
// reported on iq_size_left. Execute sees the oldest POP_W entries with zero
// latency and retires 0..POP_W of them per cycle. A flush empties the queue.

package issue_queue_pkg;

  // One decoded instruction as it waits for issue.
  typedef struct packed {
    logic [15:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } issue_queue_element_t;

  // Number of decode slots offered per cycle.
  localparam int unsigned PUSH_W = 4;

endpackage

module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,  // power of two, >= 8
  parameter int unsigned POP_W = 2    // 1..4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  issue_queue_element_t [PUSH_W-1:0]   issue_queue_element,
  input  logic [2:0]                          issue_queue_push_number,
  output logic [2:0]                          iq_size_left,
  output issue_queue_element_t [POP_W-1:0]    issue_element,
  output logic [POP_W-1:0]                    issue_valid,
  input  logic [$clog2(POP_W+1)-1:0]          issue_pop_number
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [CNT_W-1:0] free_cnt;
  logic [CNT_W-1:0] push_eff;
  logic [CNT_W-1:0] pop_eff;

  logic [PUSH_W-1:0]            wr_en;
  logic [PTR_W-1:0]             wr_idx [PUSH_W];
  logic [PTR_W-1:0]             rd_idx [POP_W];

  issue_queue_element_t         mem_q  [DEPTH];

  // Free space and clamped push/pop amounts; space is judged before this cycle's pop.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    free_cnt     = CNT_W'(DEPTH) - count_q;
    iq_size_left = (free_cnt >= CNT_W'(4)) ? 3'd4 : free_cnt[2:0];

    if (issue_queue_push_number > iq_size_left) begin
      push_eff = CNT_W'(iq_size_left);
    end else begin
      push_eff = CNT_W'(issue_queue_push_number);
    end

    if (CNT_W'(issue_pop_number) > count_q) begin
      pop_eff = count_q;
    end else begin
      pop_eff = CNT_W'(issue_pop_number);
    end
  end

  // Next-state pointers and occupancy; flush discards everything including this cycle's push/pop.
  always_comb begin
    head_d  = head_q + pop_eff[PTR_W-1:0];
    tail_d  = tail_q + push_eff[PTR_W-1:0];
    count_d = count_q + push_eff - pop_eff;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Per-slot write enables and wrapped write addresses starting at the tail.
  always_comb begin
    for (int k = 0; k < PUSH_W; k++) begin
      wr_en[k]  = !flush && (CNT_W'(k) < push_eff);
      wr_idx[k] = tail_q + PTR_W'(k);
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; accepted slots land at consecutive wrapped addresses.
  // NOTE: payload is not reset; an entry is only observed once count covers it, after it was written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH_W; k++) begin
      if (!rst && wr_en[k]) begin
        mem_q[wr_idx[k]] <= issue_queue_element[k];
      end
    end
  end

  // Zero-latency issue view of the oldest POP_W entries, valid as a thermometer of count.
  always_comb begin
    for (int j = 0; j < POP_W; j++) begin
      rd_idx[j]        = head_q + PTR_W'(j);
      issue_element[j] = mem_q[rd_idx[j]];
      issue_valid[j]   = CNT_W'(j) < count_q;
    end
  end

  // Structural invariants of the circular buffer.
  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));
  a_ptr_consistent : assert property (@(posedge clk) disable iff (rst)
    PTR_W'(tail_q - head_q) == count_q[PTR_W-1:0]);
  a_valid_thermo : assert property (@(posedge clk) disable iff (rst)
    ((issue_valid + POP_W'(1)) & issue_valid) == '0);

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed table, hand-written corner
// sequences and a randomized run, all compared with a queue-based model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned POP_W = 2;
  localparam int unsigned POPN_W = $clog2(POP_W + 1);

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              flush;
  issue_queue_element_t [PUSH_W-1:0] issue_queue_element;
  logic [2:0]                        issue_queue_push_number;
  logic [2:0]                        iq_size_left;
  issue_queue_element_t [POP_W-1:0]  issue_element;
  logic [POP_W-1:0]                  issue_valid;
  logic [POPN_W-1:0]                 issue_pop_number;

  issue_queue #(.DEPTH(DEPTH), .POP_W(POP_W)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .issue_queue_element     (issue_queue_element),
    .issue_queue_push_number (issue_queue_push_number),
    .iq_size_left            (iq_size_left),
    .issue_element           (issue_element),
    .issue_valid             (issue_valid),
    .issue_pop_number        (issue_pop_number)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_viol   = 0;
  int seq_tag  = 1;

  issue_queue_element_t model_q [$];
  issue_queue_element_t slot_v  [PUSH_W];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic issue_queue_element_t mk(input int t);
    issue_queue_element_t e;
    e.pc     = 16'(t);
    e.opcode = 7'(t * 3);
    e.rd     = 5'(t);
    e.rs1    = 5'(t + 1);
    e.rs2    = 5'(t + 2);
    return e;
  endfunction

  function automatic int model_size_left();
    int free_n = DEPTH - model_q.size();
    return (free_n > 4) ? 4 : free_n;
  endfunction

  function automatic logic [POP_W-1:0] thermo(input int n);
    logic [POP_W-1:0] v = '0;
    for (int j = 0; j < POP_W; j++) if (j < n) v[j] = 1'b1;
    return v;
  endfunction

  // Compare all visible outputs against the model.
  task automatic compare_all(input string tag);
    int n = model_q.size();
    check({tag, ".size_left"}, 64'(iq_size_left), 64'(model_size_left()));
    check({tag, ".valid"}, 64'(issue_valid), 64'(thermo(n)));
    for (int j = 0; j < POP_W; j++) begin
      if (j < n) check($sformatf("%s.elem%0d", tag, j), 64'(issue_element[j]), 64'(model_q[j]));
    end
  endtask

  // Apply one cycle of stimulus (called at negedge), advance the model, compare at the next negedge.
  task automatic drive(input bit r, input bit f, input int pn, input int popn,
                       input bit fixed, input string tag);
    int sl, ep, epop;
    if (!fixed) begin
      for (int k = 0; k < PUSH_W; k++) begin
        slot_v[k] = mk(seq_tag);
        seq_tag++;
      end
    end
    rst                     = r;
    flush                   = f;
    issue_queue_push_number = 3'(pn);
    issue_pop_number        = POPN_W'(popn);
    for (int k = 0; k < PUSH_W; k++) issue_queue_element[k] = slot_v[k];

    if (r || f) begin
      model_q.delete();
    end else begin
      sl = model_size_left();
      ep = (pn > sl) ? sl : pn;
      if (pn > sl) begin
        n_viol++;
        $display("protocol note (%s): decode requested %0d slots with only %0d free", tag, pn, sl);
      end
      epop = (popn > model_q.size()) ? model_q.size() : popn;
      repeat (epop) void'(model_q.pop_front());
      for (int k = 0; k < ep; k++) model_q.push_back(slot_v[k]);
    end

    @(posedge clk);
    @(negedge clk);
    compare_all(tag);
  endtask

  typedef struct {
    bit rst_v;
    bit flush_v;
    int push_n;
    int pop_n;
    int exp_cnt;
    int exp_size;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int sl, pn, popn;
    bit r, f;

    // Directed table: counts and free space after each cycle, derived by hand.
    vecs[0]  = '{1, 0, 0, 0,  0, 4};   // reset
    vecs[1]  = '{0, 0, 3, 0,  3, 4};
    vecs[2]  = '{0, 0, 4, 0,  7, 4};
    vecs[3]  = '{0, 0, 4, 0, 11, 4};
    vecs[4]  = '{0, 0, 4, 0, 15, 1};
    vecs[5]  = '{0, 0, 1, 0, 16, 0};   // full
    vecs[6]  = '{0, 0, 4, 0, 16, 0};   // push on full dropped
    vecs[7]  = '{0, 0, 0, 2, 14, 2};
    vecs[8]  = '{0, 0, 4, 0, 16, 0};   // near-full clamp to 2 slots
    vecs[9]  = '{0, 0, 4, 2, 14, 2};   // full: pop applies, push does not
    vecs[10] = '{0, 0, 0, 2, 12, 4};
    vecs[11] = '{0, 1, 4, 2,  0, 4};   // flush beats push and pop
    vecs[12] = '{0, 0, 0, 2,  0, 4};   // pop on empty clamps
    vecs[13] = '{0, 0, 2, 0,  2, 4};
    vecs[14] = '{0, 0, 4, 2,  4, 4};   // simultaneous push and pop
    vecs[15] = '{1, 1, 4, 0,  0, 4};   // reset together with flush

    rst = 1'b1; flush = 1'b0; issue_queue_push_number = '0; issue_pop_number = '0;
    issue_queue_element = '0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst_v, vecs[i].flush_v, vecs[i].push_n, vecs[i].pop_n, 1'b0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_valid", i), 64'(issue_valid),
            64'(thermo(vecs[i].exp_cnt)));
      check($sformatf("vec%0d.tbl_size", i), 64'(iq_size_left), 64'(vecs[i].exp_size));
    end

    // Reset then push A,B,C: A and B are visible next cycle.
    drive(1, 0, 0, 0, 1'b0, "t1_rst");
    check("t1_rst_valid", 64'(issue_valid), 64'(0));
    check("t1_rst_size", 64'(iq_size_left), 64'(4));
    slot_v[0] = mk(16'hA); slot_v[1] = mk(16'hB); slot_v[2] = mk(16'hC); slot_v[3] = mk(16'hD);
    drive(0, 0, 3, 0, 1'b1, "t1_push");
    check("t1_elem0_A", 64'(issue_element[0].pc), 64'(16'hA));
    check("t1_elem1_B", 64'(issue_element[1].pc), 64'(16'hB));
    check("t1_valid11", 64'(issue_valid), 64'(2'b11));
    drive(0, 0, 0, 2, 1'b0, "t1_pop");
    check("t1_elem0_C", 64'(issue_element[0].pc), 64'(16'hC));
    check("t1_valid01", 64'(issue_valid), 64'(2'b01));

    // Move head and tail to 14 with an empty queue, then push across the wrap point.
    drive(1, 0, 0, 0, 1'b0, "t5_rst");
    drive(0, 0, 4, 0, 1'b0, "t5_fill0");
    drive(0, 0, 4, 0, 1'b0, "t5_fill1");
    drive(0, 0, 4, 0, 1'b0, "t5_fill2");
    drive(0, 0, 2, 0, 1'b0, "t5_fill3");
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 2, 1'b0, $sformatf("t5_drain%0d", i));
    check("t5_empty_valid", 64'(issue_valid), 64'(0));
    slot_v[0] = mk(16'h57); slot_v[1] = mk(16'h58); slot_v[2] = mk(16'h59); slot_v[3] = mk(16'h5A);
    drive(0, 0, 4, 0, 1'b1, "t5_push");
    check("t5_W", 64'(issue_element[0].pc), 64'(16'h57));
    check("t5_X", 64'(issue_element[1].pc), 64'(16'h58));
    drive(0, 0, 0, 2, 1'b0, "t5_pop0");
    check("t5_Y", 64'(issue_element[0].pc), 64'(16'h59));
    check("t5_Z", 64'(issue_element[1].pc), 64'(16'h5A));
    drive(0, 0, 0, 2, 1'b0, "t5_pop1");
    check("t5_drained", 64'(issue_valid), 64'(0));
    check("t5_size", 64'(iq_size_left), 64'(4));

    // Flush at count 9 with push and pop in the same cycle.
    drive(0, 0, 4, 0, 1'b0, "t6_a");
    drive(0, 0, 4, 0, 1'b0, "t6_b");
    drive(0, 0, 1, 0, 1'b0, "t6_c");
    drive(0, 1, 4, 2, 1'b0, "t6_flush");
    check("t6_valid", 64'(issue_valid), 64'(0));
    check("t6_size", 64'(iq_size_left), 64'(4));

    // Randomized traffic against the model, with occasional overflow requests, flushes and resets.
    for (int i = 0; i < 1500; i++) begin
      sl   = model_size_left();
      pn   = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : $urandom_range(0, sl);
      popn = $urandom_range(0, POP_W);
      f    = ($urandom_range(0, 49) == 0);
      r    = ($urandom_range(0, 99) == 0);
      drive(r, f, pn, popn, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("protocol notes raised: %0d", n_viol);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
